hbmc_dru: RTL

HBMC_DRU -- requirements
Module: hbmc_dru

---
 rtl/hbmc_dru.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hbmc_dru.sv
// HyperBus read-data recovery: finds RWDS edges in oversampled ISERDES data
// and emits up to RATIO/2 DQ words per clk cycle, with glitch and timeout flags.
module hbmc_dru #(
  parameter int DQ_WIDTH       = 8,
  parameter int RATIO          = 6,
  parameter int DATA_OFFSET    = 1,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                         clk,
  input  logic                         arstn,
  input  logic                         en,
  input  logic [RATIO-1:0]             rwds_s,
  input  logic [DQ_WIDTH*RATIO-1:0]    dq_s,
  output logic [RATIO/2-1:0]           word_valid,
  output logic [RATIO/2-1:0]           word_rise,
  output logic [DQ_WIDTH*RATIO/2-1:0]  word_data,
  output logic                         timeout,
  output logic                         glitch,
  output logic [15:0]                  word_total
);

  localparam int          SLOTS  = RATIO / 2;
  localparam logic [7:0]  TO_MAX = 8'(TIMEOUT_CYCLES);

  logic                        en_a, en_b;
  logic [RATIO-1:0]            rwds_a, rwds_b;
  logic [DQ_WIDTH*RATIO-1:0]   dq_a, dq_b;
  logic                        last_rwds;
  logic                        acc_at_end;
  logic [7:0]                  to_cnt;

  logic [DQ_WIDTH-1:0]         dq_win [RATIO+DATA_OFFSET];
  logic [SLOTS-1:0]            nxt_valid, nxt_rise;
  logic [DQ_WIDTH*SLOTS-1:0]   nxt_data;
  logic                        glitch_hit;
  logic                        acc_last;
  logic [15:0]                 n_words;
  logic [16:0]                 total_sum;
  logic                        en_rise;

  assign en_rise = en & ~en_a;

  always_comb begin
    for (int unsigned k = 0; k < RATIO; k++)
      for (int unsigned i = 0; i < DQ_WIDTH; i++)
        dq_win[k][i] = dq_b[i*RATIO+k];
    // captures that spill past the stage-B window come from stage A
    for (int unsigned k = 0; k < DATA_OFFSET; k++)
      for (int unsigned i = 0; i < DQ_WIDTH; i++)
        dq_win[RATIO+k][i] = dq_a[i*RATIO+k];
  end

  always_comb begin
    logic        prev_bit;
    logic        prev_acc;
    int unsigned slot;
    nxt_valid  = '0;
    nxt_rise   = '0;
    nxt_data   = '0;
    glitch_hit = 1'b0;
    prev_bit   = last_rwds;
    prev_acc   = acc_at_end;
    slot       = 0;
    for (int unsigned j = 0; j < RATIO; j++) begin
      if (en_b && (rwds_b[j] != prev_bit)) begin
        if (prev_acc) begin
          glitch_hit = 1'b1;
          prev_acc   = 1'b0;
        end else begin
          for (int unsigned m = 0; m < SLOTS; m++) begin
            if (m == slot) begin
              nxt_valid[m]                        = 1'b1;
              nxt_rise[m]                         = rwds_b[j];
              nxt_data[m*DQ_WIDTH +: DQ_WIDTH]    = dq_win[j+DATA_OFFSET];
            end
          end
          slot     = slot + 1;
          prev_acc = 1'b1;
        end
      end else begin
        prev_acc = 1'b0;
      end
      prev_bit = rwds_b[j];
    end
    acc_last = prev_acc;
  end

  always_comb begin
    n_words = '0;
    for (int unsigned m = 0; m < SLOTS; m++)
      n_words = n_words + 16'(nxt_valid[m]);
    total_sum = {1'b0, word_total} + {1'b0, n_words};
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      en_a       <= 1'b0;
      en_b       <= 1'b0;
      rwds_a     <= '0;
      rwds_b     <= '0;
      dq_a       <= '0;
      dq_b       <= '0;
      last_rwds  <= 1'b0;
      acc_at_end <= 1'b0;
      to_cnt     <= '0;
      word_valid <= '0;
      word_rise  <= '0;
      word_data  <= '0;
      timeout    <= 1'b0;
      glitch     <= 1'b0;
      word_total <= '0;
    end else begin
      en_a       <= en;
      rwds_a     <= rwds_s;
      dq_a       <= dq_s;
      en_b       <= en_a;
      rwds_b     <= rwds_a;
      dq_b       <= dq_a;
      last_rwds  <= en_b ? rwds_b[RATIO-1] : 1'b0;
      acc_at_end <= acc_last;
      word_valid <= nxt_valid;
      word_rise  <= nxt_rise;
      word_data  <= nxt_data;

      if (glitch_hit)   glitch <= 1'b1;
      else if (en_rise) glitch <= 1'b0;

      if (en_rise)            word_total <= '0;
      else if (total_sum[16]) word_total <= '1;
      else                    word_total <= total_sum[15:0];

      // counter parks at TO_MAX so the pulse fires exactly once per stall
      if (en_rise || (|nxt_valid)) begin
        to_cnt  <= '0;
        timeout <= 1'b0;
      end else if (en_b && (to_cnt != TO_MAX)) begin
        to_cnt  <= to_cnt + 8'd1;
        timeout <= (to_cnt == TO_MAX - 8'd1);
      end else begin
        timeout <= 1'b0;
      end
    end
  end

endmodule
